// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master serving a DAC and an ADC over shared sclk/mosi
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   dac_request_write            one-cycle DAC write request (dac_address, dac_data)
//   adc_request_write/_read      one-cycle ADC register write/read request (adc_address, adc_data)
//   adc_data_readback            byte returned by the most recent completed ADC read
//   spi_busy                     high for the whole transfer, including the trailing gap
//   sclk, mosi, miso             SPI bus (mode 0, MSB first, 24-bit frames)
//   dac_cs_n, adc_cs_n           per-device chip selects, never both low
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dac_request_write,
    input  logic [4:0]  dac_address,
    input  logic [11:0] dac_data,
    input  logic        adc_request_write,
    input  logic        adc_request_read,
    input  logic [10:0] adc_address,
    input  logic [7:0]  adc_data,
    output logic [7:0]  adc_data_readback,
    output logic        spi_busy,
    output logic        sclk,
    output logic        mosi,
    output logic        dac_cs_n,
    output logic        adc_cs_n,
    input  logic        miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] frame_q, frame_d;
    logic        rd_q, rd_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rb_q, rb_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        dac_cs_n_q, dac_cs_n_d;
    logic        adc_cs_n_q, adc_cs_n_d;
    logic        busy_q, busy_d;
    logic        phase_end;

    assign phase_end = (cnt_q == DIV_LAST);

    // All pins come straight from flops so chip selects cannot glitch on
    // state decode; each pin's next value is computed alongside the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        rd_d       = rd_q;
        rx_d       = rx_q;
        rb_d       = rb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        dac_cs_n_d = dac_cs_n_q;
        adc_cs_n_d = adc_cs_n_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                bit_d = 5'd0;
                // Fixed priority: ADC read, then ADC write, then DAC write.
                if (adc_request_read) begin
                    frame_d    = {1'b1, 4'b0000, adc_address, 8'h00};
                    rd_d       = 1'b1;
                    adc_cs_n_d = 1'b0;
                    dac_cs_n_d = 1'b1;
                end else if (adc_request_write) begin
                    frame_d    = {1'b0, 4'b0000, adc_address, adc_data};
                    rd_d       = 1'b0;
                    adc_cs_n_d = 1'b0;
                    dac_cs_n_d = 1'b1;
                end else if (dac_request_write) begin
                    frame_d    = {3'b000, dac_address, dac_data, 4'h0};
                    rd_d       = 1'b0;
                    dac_cs_n_d = 1'b0;
                    adc_cs_n_d = 1'b1;
                end
                if (adc_request_read || adc_request_write || dac_request_write) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    mosi_d  = frame_d[23];
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 8'd1;
                if (phase_end) begin
                    cnt_d   = 8'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                if (phase_end) begin
                    cnt_d = 8'd0;
                    if (!sclk_q) begin
                        // Rising edge: the readback byte is the last 8 bits of a read frame.
                        sclk_d = 1'b1;
                        if (rd_q && (bit_q >= 5'd16)) begin
                            rx_d = {rx_q[6:0], miso};
                        end
                    end else begin
                        // Falling edge: present the next frame bit.
                        sclk_d  = 1'b0;
                        frame_d = {frame_q[22:0], 1'b0};
                        mosi_d  = frame_q[22];
                        if (bit_q == 5'd23) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 8'd1;
                if (phase_end) begin
                    cnt_d      = 8'd0;
                    state_d    = GAP;
                    dac_cs_n_d = 1'b1;
                    adc_cs_n_d = 1'b1;
                    mosi_d     = 1'b0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 8'd1;
                if (phase_end) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (rd_q) begin
                        rb_d = rx_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 5'd0;
            frame_q    <= 24'd0;
            rd_q       <= 1'b0;
            rx_q       <= 8'h00;
            rb_q       <= 8'h00;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            dac_cs_n_q <= 1'b1;
            adc_cs_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            rd_q       <= rd_d;
            rx_q       <= rx_d;
            rb_q       <= rb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            dac_cs_n_q <= dac_cs_n_d;
            adc_cs_n_q <= adc_cs_n_d;
            busy_q     <= busy_d;
        end
    end

    assign adc_data_readback = rb_q;
    assign spi_busy          = busy_q;
    assign sclk              = sclk_q;
    assign mosi              = mosi_q;
    assign dac_cs_n          = dac_cs_n_q;
    assign adc_cs_n          = adc_cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        reset_n;
    logic        dac_request_write;
    logic [4:0]  dac_address;
    logic [11:0] dac_data;
    logic        adc_request_write;
    logic        adc_request_read;
    logic [10:0] adc_address;
    logic [7:0]  adc_data;
    logic [7:0]  adc_data_readback;
    logic        spi_busy;
    logic        sclk;
    logic        mosi;
    logic        dac_cs_n;
    logic        adc_cs_n;
    logic        miso;

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dac_request_write (dac_request_write),
        .dac_address       (dac_address),
        .dac_data          (dac_data),
        .adc_request_write (adc_request_write),
        .adc_request_read  (adc_request_read),
        .adc_address       (adc_address),
        .adc_data          (adc_data),
        .adc_data_readback (adc_data_readback),
        .spi_busy          (spi_busy),
        .sclk              (sclk),
        .mosi              (mosi),
        .dac_cs_n          (dac_cs_n),
        .adc_cs_n          (adc_cs_n),
        .miso              (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  reqs;       // {adc_read, adc_write, dac_write}
        logic [10:0] aaddr;
        logic [7:0]  adata;
        logic [4:0]  daddr;
        logic [11:0] ddata;
        logic [7:0]  resp;       // byte the ADC model returns
        logic [23:0] exp_frame;
        logic        exp_adc;
        logic [7:0]  exp_rb;
    } vec_t;

    typedef struct {
        logic [23:0] frame;
        logic        adc;
        logic [7:0]  rb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bus monitor: samples on the falling clk edge, away from DUT updates.
    logic        in_frame = 1'b0;
    logic        cap_adc = 1'b0;
    logic [23:0] cap = 24'd0;
    int          mon_rises = 0;
    int          busy_cnt = 0;
    int          gap_cnt = 0;
    logic        both_low = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  miso_resp = 8'h00;

    // ADC model: drives readback bits during frame bits 16..23, changing
    // after each sclk rise so the value is stable at the next rise.
    assign miso = (in_frame && cap_adc && mon_rises >= 16 && mon_rises < 24)
                  ? miso_resp[23 - mon_rises] : 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame  = 1'b0;
            mon_rises = 0;
            busy_cnt  = 0;
            gap_cnt   = 0;
            both_low  = 1'b0;
            prev_sclk = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (!dac_cs_n && !adc_cs_n) both_low = 1'b1;
            if (!in_frame && (!dac_cs_n || !adc_cs_n)) begin
                in_frame  = 1'b1;
                cap       = 24'd0;
                mon_rises = 0;
                cap_adc   = !adc_cs_n;
                chk("frame_expected", 32'(sb.size() > 0), 32'd1);
            end else if (in_frame && dac_cs_n && adc_cs_n) begin
                in_frame = 1'b0;
                if (sb.size() > 0) begin
                    chk("mosi_frame", 32'(cap), 32'(sb[0].frame));
                    chk("cs_select_adc", 32'(cap_adc), 32'(sb[0].adc));
                    chk("sclk_rises", mon_rises, 24);
                    chk("cs_exclusive", 32'(both_low), 32'd0);
                end
            end else if (in_frame && sclk && !prev_sclk) begin
                cap = {cap[22:0], mosi};
                mon_rises++;
            end
            if (spi_busy) begin
                busy_cnt++;
                if (dac_cs_n && adc_cs_n) gap_cnt++;
            end
            if (!spi_busy && prev_busy) begin
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("busy_cycles", busy_cnt, 51 * CLK_DIV);
                    chk("gap_cycles", gap_cnt, CLK_DIV);
                    chk("readback", 32'(adc_data_readback), 32'(e.rb));
                end
                busy_cnt = 0;
                gap_cnt  = 0;
            end
            prev_sclk = sclk;
            prev_busy = spi_busy;
        end
    end

    // Called at a falling clk edge; the request is sampled on the next rising edge.
    task automatic do_req(input logic [2:0] reqs, input logic [10:0] aaddr, input logic [7:0] adata,
                          input logic [4:0] daddr, input logic [11:0] ddata, input logic want_busy);
        adc_request_read  = reqs[2];
        adc_request_write = reqs[1];
        dac_request_write = reqs[0];
        adc_address       = aaddr;
        adc_data          = adata;
        dac_address       = daddr;
        dac_data          = ddata;
        @(negedge clk);
        adc_request_read  = 1'b0;
        adc_request_write = 1'b0;
        dac_request_write = 1'b0;
        if (want_busy) chk("busy_rise", 32'(spi_busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!spi_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    function automatic exp_t mk(input logic [23:0] f, input logic a, input logic [7:0] rb);
        exp_t e;
        e.frame = f;
        e.adc   = a;
        e.rb    = rb;
        return e;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3'b100, 11'h0F1, 8'h00, 5'h00, 12'h000, 8'h5A, 24'h80F100, 1'b1, 8'h5A};
        vecs[1] = '{3'b010, 11'h014, 8'h3C, 5'h00, 12'h000, 8'hFF, 24'h00143C, 1'b1, 8'h5A};
        vecs[2] = '{3'b001, 11'h000, 8'h00, 5'h03, 12'hABC, 8'h00, 24'h03ABC0, 1'b0, 8'h5A};
        vecs[3] = '{3'b001, 11'h000, 8'h00, 5'h1F, 12'hFFF, 8'h00, 24'h1FFFF0, 1'b0, 8'h5A};
        vecs[4] = '{3'b010, 11'h7FF, 8'hFF, 5'h00, 12'h000, 8'h00, 24'h07FFFF, 1'b1, 8'h5A};
        vecs[5] = '{3'b100, 11'h000, 8'h00, 5'h00, 12'h000, 8'hA5, 24'h800000, 1'b1, 8'hA5};

        reset_n = 1'b0;
        dac_request_write = 1'b0;
        adc_request_write = 1'b0;
        adc_request_read  = 1'b0;
        dac_address = 5'h00;
        dac_data    = 12'h000;
        adc_address = 11'h000;
        adc_data    = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_dac_cs_n", 32'(dac_cs_n), 32'd1);
        chk("rst_adc_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_busy", 32'(spi_busy), 32'd0);
        chk("rst_readback", 32'(adc_data_readback), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Each vector is requested on the first cycle after busy falls.
        for (int i = 0; i < 6; i++) begin
            miso_resp = vecs[i].resp;
            sb.push_back(mk(vecs[i].exp_frame, vecs[i].exp_adc, vecs[i].exp_rb));
            do_req(vecs[i].reqs, vecs[i].aaddr, vecs[i].adata, vecs[i].daddr, vecs[i].ddata, 1'b1);
            wait_idle("vec_done");
        end

        // Simultaneous read + DAC write: only the read runs; requests while busy are dropped.
        repeat (3) @(negedge clk);
        miso_resp = 8'h3C;
        sb.push_back(mk(24'h840000, 1'b1, 8'h3C));
        do_req(3'b101, 11'h400, 8'h00, 5'h07, 12'h123, 12'h0 == 12'h0);
        repeat (40) @(negedge clk);
        do_req(3'b001, 11'h000, 8'h00, 5'h02, 12'h456, 1'b0);
        repeat (30) @(negedge clk);
        do_req(3'b100, 11'h001, 8'h00, 5'h00, 12'h000, 1'b0);
        wait_idle("arb_done");
        repeat (20) @(negedge clk);
        chk("no_extra_busy", 32'(spi_busy), 32'd0);
        chk("no_extra_frame", sb.size(), 0);

        // Asynchronous reset during bit 10 of a DAC frame.
        sb.push_back(mk(24'h03ABC0, 1'b0, 8'h3C));
        do_req(3'b001, 11'h000, 8'h00, 5'h03, 12'hABC, 1'b1);
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (mon_rises >= 10) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("reach_bit10", 32'(reached), 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_dac_cs_n", 32'(dac_cs_n), 32'd1);
        chk("abort_adc_cs_n", 32'(adc_cs_n), 32'd1);
        chk("abort_busy", 32'(spi_busy), 32'd0);
        chk("abort_readback", 32'(adc_data_readback), 32'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back(mk(24'h03ABC0, 1'b0, 8'h00));
        do_req(3'b001, 11'h000, 8'h00, 5'h03, 12'hABC, 1'b1);
        wait_idle("post_reset_done");
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
